// File: rtl/alu_issue.sv
`default_nettype none
// ============================================================================
//  Module      : alu_issue
//  Description : Instruction issue stage. Decodes a 16-bit instruction, reads
//                operands from a small register file, drives an external ALU
//                with a one-hot select for exactly one cycle, then writes the
//                result back. LDI and NOP bypass the ALU.
//  Revision    : 1.0 - initial release
// ============================================================================
module alu_issue #(
    parameter int          NREG    = 16,
    parameter logic [15:0] RST_VAL = 16'h0000
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic [15:0] instr,
    input  logic        instr_valid,
    output logic        instr_ready,
    output logic [15:0] alu_a,
    output logic [15:0] alu_b,
    output logic [5:0]  alu_sel,
    input  logic [15:0] alu_out,
    output logic        done,
    output logic        illegal,
    input  logic [3:0]  dbg_addr,
    output logic [15:0] dbg_data
);

    localparam logic [1:0] c_idle = 2'd0;
    localparam logic [1:0] c_read = 2'd1;
    localparam logic [1:0] c_exec = 2'd2;
    localparam logic [1:0] c_wb   = 2'd3;

    localparam logic [3:0] c_op_nop = 4'h0;
    localparam logic [3:0] c_op_add = 4'h1;
    localparam logic [3:0] c_op_sub = 4'h2;
    localparam logic [3:0] c_op_cmp = 4'h3;
    localparam logic [3:0] c_op_and = 4'h4;
    localparam logic [3:0] c_op_or  = 4'h5;
    localparam logic [3:0] c_op_xor = 4'h6;
    localparam logic [3:0] c_op_ldi = 4'h7;

    logic [1:0]  r_state;
    logic [1:0]  w_next_state;
    logic [3:0]  r_op;
    logic [3:0]  r_rd;
    logic [7:0]  r_imm;
    logic [15:0] r_result;
    logic        r_illegal;
    logic [15:0] r_regs [NREG];

    logic        w_accept;
    logic [3:0]  w_rs;
    logic [15:0] w_rd_val;
    logic [15:0] w_rs_val;
    logic        w_we;
    logic [15:0] w_wdata;

    // One-hot ALU select for each arithmetic/logic opcode; zero otherwise
    function automatic logic [5:0] f_decode(input logic [3:0] op);
        case (op)
            c_op_add: f_decode = 6'b100000;
            c_op_sub: f_decode = 6'b010000;
            c_op_cmp: f_decode = 6'b001000;
            c_op_and: f_decode = 6'b000100;
            c_op_or:  f_decode = 6'b000010;
            c_op_xor: f_decode = 6'b000001;
            default:  f_decode = 6'b000000;
        endcase
    endfunction

    assign w_accept = instr_valid & instr_ready;
    assign w_rs     = r_imm[7:4];

    // CMP only updates flags downstream, so it is excluded from writeback
    assign w_we = (r_state == c_wb) &&
                  ((r_op == c_op_add) || (r_op == c_op_sub) || (r_op == c_op_and) ||
                   (r_op == c_op_or)  || (r_op == c_op_xor) || (r_op == c_op_ldi));
    assign w_wdata = (r_op == c_op_ldi) ? {8'h00, r_imm} : r_result;

    // State register
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_state <= c_idle;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic: ALU ops take the long path, LDI/NOP go straight to WB
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_idle: begin
                if (w_accept) begin
                    if (instr[15:12] >= c_op_add && instr[15:12] <= c_op_xor) begin
                        w_next_state = c_read;
                    end else if (instr[15:12] == c_op_nop || instr[15:12] == c_op_ldi) begin
                        w_next_state = c_wb;
                    end else begin
                        w_next_state = c_idle;
                    end
                end
            end
            c_read:  w_next_state = c_exec;
            c_exec:  w_next_state = c_wb;
            c_wb:    w_next_state = c_idle;
            default: w_next_state = c_idle;
        endcase
    end

    // Outputs decoded from state; ready is held low while reset is asserted
    always_comb begin
        instr_ready = (r_state == c_idle) && !RESET;
        done        = (r_state == c_wb);
    end

    assign illegal = r_illegal;

    // Operand reads; addresses beyond the register file read as zero
    always_comb begin
        w_rd_val = 16'h0000;
        w_rs_val = 16'h0000;
        for (int i = 0; i < NREG; i++) begin
            if (r_rd == 4'(i)) w_rd_val = r_regs[i];
            if (w_rs == 4'(i)) w_rs_val = r_regs[i];
        end
    end

    // Debug read port, shows pre-write contents during WB
    always_comb begin
        dbg_data = 16'h0000;
        for (int i = 0; i < NREG; i++) begin
            if (dbg_addr == 4'(i)) dbg_data = r_regs[i];
        end
    end

    // Datapath: instruction latch, operand/select registers, result, regfile
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_op      <= 4'h0;
            r_rd      <= 4'h0;
            r_imm     <= 8'h00;
            r_result  <= 16'h0000;
            r_illegal <= 1'b0;
            alu_a     <= 16'h0000;
            alu_b     <= 16'h0000;
            alu_sel   <= 6'b000000;
            for (int i = 0; i < NREG; i++) begin
                r_regs[i] <= RST_VAL;
            end
        end else begin
            r_illegal <= w_accept && instr[15];
            // Select is loaded on READ->EXEC so it is nonzero for EXEC only
            alu_sel   <= (r_state == c_read) ? f_decode(r_op) : 6'b000000;
            if (w_accept) begin
                r_op  <= instr[15:12];
                r_rd  <= instr[11:8];
                r_imm <= instr[7:0];
            end
            if (r_state == c_read) begin
                alu_a <= w_rd_val;
                alu_b <= w_rs_val;
            end
            if (r_state == c_exec) begin
                r_result <= alu_out;
            end
            // Writes to addresses beyond the register file match no entry
            for (int i = 0; i < NREG; i++) begin
                if (w_we && r_rd == 4'(i)) r_regs[i] <= w_wdata;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_alu_issue.sv
`default_nettype none
// ============================================================================
//  Module      : tb_alu_issue
//  Description : Scoreboard bench for alu_issue. Stimulus pushes expected
//                ALU-select, done and illegal events; a negedge monitor pops
//                and compares them as the DUT presents them.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_issue;

    localparam int K_EXEC = 0;
    localparam int K_DONE = 1;
    localparam int K_ILL  = 2;

    typedef struct {
        int          kind;
        logic [15:0] a;
        logic [15:0] b;
        logic [5:0]  sel;
    } exp_t;

    logic        CLK;
    logic        RESET;
    logic [15:0] instr;
    logic        instr_valid;
    logic        instr_ready;
    logic [15:0] alu_a;
    logic [15:0] alu_b;
    logic [5:0]  alu_sel;
    logic [15:0] alu_out;
    logic        done;
    logic        illegal;
    logic [3:0]  dbg_addr;
    logic [15:0] dbg_data;

    int   n_tests;
    int   n_fail;
    exp_t q[$];
    exp_t e;
    logic [15:0] v;

    alu_issue #(.NREG(8), .RST_VAL(16'h0000)) dut (
        .CLK(CLK), .RESET(RESET), .instr(instr), .instr_valid(instr_valid),
        .instr_ready(instr_ready), .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel),
        .alu_out(alu_out), .done(done), .illegal(illegal),
        .dbg_addr(dbg_addr), .dbg_data(dbg_data)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Reference ALU driven by the stage
    always_comb begin
        alu_out = 16'h0000;
        case (alu_sel)
            6'b100000: alu_out = alu_a + alu_b;
            6'b010000: alu_out = alu_a - alu_b;
            6'b001000: alu_out = alu_a - alu_b;
            6'b000100: alu_out = alu_a & alu_b;
            6'b000010: alu_out = alu_a | alu_b;
            6'b000001: alu_out = alu_a ^ alu_b;
            default:   alu_out = 16'h0000;
        endcase
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push(input int kind, input logic [15:0] a, input logic [15:0] b,
                        input logic [5:0] sel);
        exp_t x;
        x.kind = kind; x.a = a; x.b = b; x.sel = sel;
        q.push_back(x);
    endtask

    // Monitor: every observed event must match the head of the queue
    always @(negedge CLK) begin
        if (!RESET) begin
            if (alu_sel != 6'b000000) begin
                if (q.size() == 0) chk("unexpected_exec", 64'(alu_sel), 64'(0));
                else begin
                    e = q.pop_front();
                    chk("exec_kind", 64'(K_EXEC), 64'(e.kind));
                    chk("exec_ops", {16'h0, alu_a, alu_b, 10'h0, alu_sel},
                        {16'h0, e.a, e.b, 10'h0, e.sel});
                end
            end
            if (done) begin
                if (q.size() == 0) chk("unexpected_done", 64'(1), 64'(0));
                else begin
                    e = q.pop_front();
                    chk("done_kind", 64'(K_DONE), 64'(e.kind));
                end
            end
            if (illegal) begin
                if (q.size() == 0) chk("unexpected_illegal", 64'(1), 64'(0));
                else begin
                    e = q.pop_front();
                    chk("illegal_kind", 64'(K_ILL), 64'(e.kind));
                end
            end
        end
    end

    task automatic wait_ready();
        int n;
        n = 0;
        while (!instr_ready && n < 20) begin
            @(posedge CLK); #1;
            n++;
        end
        if (!instr_ready) chk("ready_timeout", 64'(0), 64'(1));
    endtask

    // Present one instruction, hold until accepted, then wait for IDLE
    task automatic issue(input logic [15:0] ins);
        instr = ins;
        instr_valid = 1'b1;
        wait_ready();
        @(posedge CLK); #1;
        instr_valid = 1'b0;
        wait_ready();
    endtask

    task automatic alu_op(input logic [15:0] ins, input logic [15:0] a,
                          input logic [15:0] b, input logic [5:0] sel);
        push(K_EXEC, a, b, sel);
        push(K_DONE, 16'h0, 16'h0, 6'h0);
        issue(ins);
    endtask

    task automatic short_op(input logic [15:0] ins);
        push(K_DONE, 16'h0, 16'h0, 6'h0);
        issue(ins);
    endtask

    task automatic check_reg(input string name, input logic [3:0] addr, input logic [15:0] val);
        dbg_addr = addr;
        @(posedge CLK); #1;
        chk(name, 64'(dbg_data), 64'(val));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        n_tests = 0; n_fail = 0;
        RESET = 1'b1; instr = 16'h0000; instr_valid = 1'b0; dbg_addr = 4'd0;
        #3;
        chk("rst_ready", 64'(instr_ready), 64'(0));
        chk("rst_outs", {32'h0, alu_a, alu_b}, 64'(0));
        chk("rst_flags", {56'h0, alu_sel, done, illegal}, 64'(0));
        check_reg("rst_r1", 4'd1, 16'h0000);
        RESET = 1'b0;
        #1;
        chk("ready_after_rst", 64'(instr_ready), 64'(1));
        @(posedge CLK); #1;

        // LDI / ADD
        short_op(16'h7105);
        short_op(16'h7203);
        alu_op(16'h1120, 16'h0005, 16'h0003, 6'b100000);
        check_reg("add_r1", 4'd1, 16'h0008);
        check_reg("add_r2", 4'd2, 16'h0003);

        // CMP leaves rd unchanged
        alu_op(16'h3120, 16'h0008, 16'h0003, 6'b001000);
        check_reg("cmp_r1", 4'd1, 16'h0008);

        // SUB, AND, OR, XOR
        alu_op(16'h2120, 16'h0008, 16'h0003, 6'b010000);
        check_reg("sub_r1", 4'd1, 16'h0005);
        alu_op(16'h4120, 16'h0005, 16'h0003, 6'b000100);
        check_reg("and_r1", 4'd1, 16'h0001);
        alu_op(16'h5120, 16'h0001, 16'h0003, 6'b000010);
        check_reg("or_r1", 4'd1, 16'h0003);
        short_op(16'h74F0);
        alu_op(16'h6410, 16'h00F0, 16'h0003, 6'b000001);
        check_reg("xor_r4", 4'd4, 16'h00F3);

        // NOP
        short_op(16'h0000);
        check_reg("nop_r1", 4'd1, 16'h0003);

        // Illegal opcode
        push(K_ILL, 16'h0, 16'h0, 6'h0);
        issue(16'hF123);
        chk("ill_ready", 64'(instr_ready), 64'(1));
        check_reg("ill_r1", 4'd1, 16'h0003);
        check_reg("ill_r2", 4'd2, 16'h0003);
        check_reg("ill_r4", 4'd4, 16'h00F3);

        // Out-of-range rd/rs with NREG=8
        short_op(16'h7955);
        check_reg("oor_r9", 4'd9, 16'h0000);
        alu_op(16'h1190, 16'h0003, 16'h0000, 6'b100000);
        check_reg("oor_r1", 4'd1, 16'h0003);

        // Back-to-back LDI stream, valid held high
        instr = 16'h7601;
        instr_valid = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            chk("stream_ready_hi", 64'(instr_ready), 64'(1));
            push(K_DONE, 16'h0, 16'h0, 6'h0);
            @(posedge CLK); #1;
            chk("stream_ready_lo", 64'(instr_ready), 64'(0));
            instr = 16'h7600 | 16'(k + 1);
            @(posedge CLK); #1;
        end
        instr_valid = 1'b0;
        check_reg("stream_r6", 4'd6, 16'h0003);

        // Reset during EXEC of XOR R3,R4
        short_op(16'h730A);
        instr = 16'h6340;
        instr_valid = 1'b1;
        wait_ready();
        @(posedge CLK); #1;
        instr_valid = 1'b0;
        @(posedge CLK); #1;
        chk("xor_exec_sel", 64'(alu_sel), 64'(6'b000001));
        chk("xor_exec_ops", {32'h0, alu_a, alu_b}, {32'h0, 16'h000A, 16'h00F3});
        RESET = 1'b1;
        #1;
        chk("rst_mid_sel", 64'(alu_sel), 64'(0));
        chk("rst_mid_ready", 64'(instr_ready), 64'(0));
        check_reg("rst_mid_r3", 4'd3, 16'h0000);
        RESET = 1'b0;
        #1;
        chk("rst_mid_ready_after", 64'(instr_ready), 64'(1));
        @(posedge CLK); #1;
        check_reg("rst_mid_r4", 4'd4, 16'h0000);

        // ADD R5,R5 doubling chain up to 0x8000, then wrap to zero
        short_op(16'h7580);
        v = 16'h0080;
        for (int k = 0; k < 8; k++) begin
            alu_op(16'h1550, v, v, 6'b100000);
            v = v + v;
        end
        check_reg("chain_r5", 4'd5, 16'h8000);
        alu_op(16'h1550, 16'h8000, 16'h8000, 6'b100000);
        check_reg("wrap_r5", 4'd5, 16'h0000);

        repeat (3) @(posedge CLK);
        chk("queue_empty", 64'(q.size()), 64'(0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/alu_issue.md
ALU_ISSUE -- requirements
Module: alu_issue

Interface
Parameters
REQ-001 SHALL have parameter NREG, default 16, number of 16-bit general registers; legal range 2..16.
REQ-002 SHALL have parameter RST_VAL, default 16'h0000, reset value of every register.
Ports
REQ-003 SHALL have CLK  input  1  sole clock; all state updates on its rising edge.
REQ-004 SHALL have RESET  input  1  one clock; reset is asynchronous and active-high.
REQ-005 SHALL have instr  input  16  instruction word: [15:12] opcode, [11:8] rd, [7:4] rs, [7:0] imm8.
REQ-006 SHALL have instr_valid  input  1  instr holds a valid instruction.
REQ-007 SHALL have instr_ready  output  1  stage can accept an instruction this cycle.
REQ-008 SHALL have alu_a  output  16  operand A to ALU, registered.
REQ-009 SHALL have alu_b  output  16  operand B to ALU, registered.
REQ-010 SHALL have alu_sel  output  6  one-hot ALU/PSR op select, registered.
REQ-011 SHALL have alu_out  input  16  ALU result for current alu_sel.
REQ-012 SHALL have done  output  1  one-cycle pulse on instruction retirement.
REQ-013 SHALL have illegal  output  1  one-cycle pulse when an undefined opcode is accepted.
REQ-014 SHALL have dbg_addr  input  4  debug register read address.
REQ-015 SHALL have dbg_data  output  16  combinational read of register dbg_addr.

Function
REQ-016 SHALL use FSM states IDLE, READ, EXEC, WB.
REQ-017 SHALL drive instr_ready high only in IDLE; acceptance = instr_valid & instr_ready at a rising edge.
REQ-018 SHALL latch opcode, rd, rs, imm8 on acceptance; instr is ignored until back in IDLE.
REQ-019 SHALL decode opcodes: 1 ADD 6'b100000, 2 SUB 6'b010000, 3 CMP 6'b001000, 4 AND 6'b000100, 5 OR 6'b000010, 6 XOR 6'b000001, 7 LDI, 0 NOP; 8..F illegal.
REQ-020 SHALL, for opcodes 1..6: IDLE -> READ -> EXEC -> WB -> IDLE, one cycle each.
REQ-021 SHALL, in READ, register alu_a <= R[rd], alu_b <= R[rs], valid from EXEC.
REQ-022 SHALL drive alu_sel to the decoded one-hot value only during EXEC, 6'b000000 in every other cycle, so downstream PSR updates exactly once per instruction.
REQ-023 SHALL capture alu_out at the end of EXEC into a result register.
REQ-024 SHALL, in WB, write result to R[rd] for ADD/SUB/AND/OR/XOR; CMP performs no register write.
REQ-025 SHALL, for LDI: IDLE -> WB -> IDLE; R[rd] <= {8'h00, imm8}; alu_sel stays zero.
REQ-026 SHALL, for NOP: IDLE -> WB -> IDLE; no write, alu_sel stays zero.
REQ-027 SHALL, for illegal opcodes: pulse illegal in the cycle after acceptance, stay in IDLE, no write, no done.
REQ-028 SHALL pulse done for exactly one cycle in WB for ALU ops, LDI and NOP.
REQ-029 SHALL ignore writes/reads to rd or rs >= NREG (write dropped, read returns 16'h0000); dbg_addr >= NREG returns 16'h0000.
REQ-030 SHALL return pre-write contents on dbg_data during the WB cycle; new value visible from the next cycle.
REQ-031 SHALL allow rd == rs; operands are both old R[rd].
REQ-032 SHALL accept back-to-back instructions with no bubble beyond the return to IDLE (throughput: one ALU op per 4 cycles, LDI/NOP per 2).

Reset
REQ-033 SHALL, while RESET high, force state IDLE, all registers to RST_VAL, alu_a = alu_b = 16'h0000, alu_sel = 6'b000000, done = illegal = 0, instr_ready = 0.
REQ-034 SHALL abort any in-flight instruction on RESET assertion mid-operation with no register write.
REQ-035 SHALL raise instr_ready in the first cycle after RESET deasserts.

Verification
REQ-036 SHALL cover: LDI R1,0x05; LDI R2,0x03; ADD R1,R2 -> alu_a=0x0005, alu_b=0x0003, alu_sel=6'b100000 for one cycle, R1=0x0008, done once.
REQ-037 SHALL cover: R1=0x0008, R2=0x0003, CMP R1,R2 -> alu_sel=6'b001000 one cycle, R1 unchanged 0x0008, done pulses.
REQ-038 SHALL cover: instr=16'hF123 valid -> illegal pulses one cycle, no done, all registers unchanged, instr_ready high next cycle.
REQ-039 SHALL cover: RESET asserted during EXEC of XOR R3,R4 -> R3=0x0000, alu_sel=0 immediately, instr_ready high one cycle after release.
REQ-040 SHALL cover: instr_valid held high with LDI stream -> one accept every 2 cycles, alu_sel never nonzero.
REQ-041 SHALL cover: ADD R5,R5 with R5=0x8000 -> alu_a=alu_b=0x8000, R5=0x0000 (ALU wrap).
